// File: rtl/rng_word_arbiter.sv
// rng_word_arbiter: 16-bit Fibonacci LFSR mixed with one ring-oscillator bit per
// clock, handing out fully refreshed words to NREQ requesters in round-robin order.
// Optional entropy health check enabled by defining RNG_HEALTH_CHECK_EN.
module rng_word_arbiter #(
  parameter int NREQ        = 2,
  parameter int REFRESH     = 16,
  parameter int STUCK_LIMIT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            random,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [15:0]     data,
  output logic            avail,
  output logic            fault
);

  localparam int         PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0] REF_CNT = 8'(REFRESH);

  // Parameter sanity; the fill and run counters are 8 bits wide.
  if (NREQ < 1 || NREQ > 8) begin : g_bad_nreq
    $error("rng_word_arbiter: NREQ out of range");
  end
  if (REFRESH < 16 || REFRESH > 255) begin : g_bad_refresh
    $error("rng_word_arbiter: REFRESH out of range");
  end
  if (STUCK_LIMIT < 1 || STUCK_LIMIT > 255) begin : g_bad_stuck
    $error("rng_word_arbiter: STUCK_LIMIT out of range");
  end

  // Index 0 is the leftmost bit, so the packed value reads MSB-first as written.
  logic [0:15]     lfsr;
  logic            fb;
  logic [7:0]      cnt;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   win_idx;
  logic            win_found;
  logic [NREQ-1:0] win_onehot;
  logic            fault_q;
  int              idx;

  assign fb    = random ^ lfsr[10] ^ lfsr[12] ^ lfsr[13] ^ lfsr[15];
  assign avail = (cnt == REF_CNT) && !fault_q;
  assign fault = fault_q;

  // Round-robin search starting just after the last winner.
  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    idx        = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!win_found && req[idx]) begin
        win_found       = 1'b1;
        win_idx         = PW'(idx);
        win_onehot      = '0;
        win_onehot[idx] = 1'b1;
      end
    end
  end

  // LFSR shifts every edge; a grant captures the pre-shift word and restarts the fill count.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= 16'hACE1;
      cnt  <= '0;
      gnt  <= '0;
      data <= '0;
      ptr  <= PW'(NREQ - 1);
    end else begin
      lfsr <= {fb, lfsr[0:14]};
      if (avail && win_found) begin
        gnt  <= win_onehot;
        data <= lfsr;
        ptr  <= win_idx;
        cnt  <= '0;
      end else begin
        gnt <= '0;
        if (cnt != REF_CNT) cnt <= cnt + 8'd1;
      end
    end
  end

`ifdef RNG_HEALTH_CHECK_EN
  logic       prev_bit;
  logic [7:0] run;

  // Count consecutive repeats of the entropy bit; a long run latches the fault until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_bit <= 1'b0;
      run      <= '0;
      fault_q  <= 1'b0;
    end else begin
      prev_bit <= random;
      if (random == prev_bit) begin
        if (run != 8'hFF) run <= run + 8'd1;
        if (({1'b0, run} + 9'd1) >= 9'(STUCK_LIMIT)) fault_q <= 1'b1;
      end else begin
        run <= '0;
      end
    end
  end
`else
  assign fault_q = 1'b0;
`endif

endmodule
